// File: rtl/seven_seg_scan_decoder_pkg.sv
// Shared definitions for the seven-segment scan decoder and display driver.
// Select codes, segment table and slot encoding.
package seven_seg_scan_decoder_pkg;

  localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

  localparam logic [2:0] SEL_ONES     = 3'b011;
  localparam logic [2:0] SEL_TENS     = 3'b101;
  localparam logic [2:0] SEL_HUNDREDS = 3'b110;
  localparam logic [2:0] SEL_NONE     = 3'b111;

  // Active-low patterns, entry i shows digit i.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0011000,
    7'b0000000,
    7'b1111000,
    7'b0000010,
    7'b0010010,
    7'b0011001,
    7'b0110000,
    7'b0100100,
    7'b1111001,
    7'b1000000
  };

  typedef enum logic [1:0] {
    SLOT_ONES     = 2'd0,
    SLOT_TENS     = 2'd1,
    SLOT_HUNDREDS = 2'd2,
    SLOT_NONE     = 2'd3
  } slot_e;

  typedef struct packed {
    logic [3:0] digit;
    logic       err;
  } slot_t;

  function automatic slot_e sel_to_slot(
    input logic [2:0] sel
  );
    slot_e s;
    case (sel)
      SEL_ONES:     s = SLOT_ONES;
      SEL_TENS:     s = SLOT_TENS;
      SEL_HUNDREDS: s = SLOT_HUNDREDS;
      default:      s = SLOT_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_scan_decoder_if.sv
// Scan bus between a multiplexed display and the decoder.
// master drives the scan, slave reconstructs the score.
interface seven_seg_scan_decoder_if;

  logic [2:0] sel;
  logic [6:0] seg;
  logic [7:0] score;
  logic       score_valid;
  logic       frame_err;

  modport master (
    output sel,
    output seg,
    input  score,
    input  score_valid,
    input  frame_err
  );

  modport slave (
    input  sel,
    input  seg,
    output score,
    output score_valid,
    output frame_err
  );

endinterface

// File: rtl/seg_pattern_to_digit.sv
// Maps an active-low segment pattern to its decimal digit.
// Unknown patterns give digit 0 with pattern_ok low.
module seg_pattern_to_digit
  import seven_seg_scan_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       pattern_ok
);

  always_comb begin
    digit      = '0;
    pattern_ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (pattern == SEG_TABLE[i]) begin
        digit      = 4'(i);
        pattern_ok = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Rebuilds a 3-digit score from a scanned seven-segment display.
// Each digit must dwell stably before it is captured into its slot.
module seven_seg_scan_decoder
  import seven_seg_scan_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input logic                     clk,
  input logic                     rst_n,
  seven_seg_scan_decoder_if.slave bus
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 2);

  logic [2:0] sel_q;
  logic [2:0] sel_p;
  logic [6:0] seg_q;
  logic [6:0] seg_p;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  slot_e      slot;
  logic [1:0] idx;
  logic       same;
  logic       inc;
  logic       capture;

  logic [3:0] dec_digit;
  logic       dec_ok;

  slot_t [2:0] slot_q;
  slot_t [2:0] slot_d;
  logic  [2:0] cap_q;
  logic  [2:0] cap_d;
  logic        frame_done;
  logic  [9:0] value;
  logic        bad;

  logic [7:0] score_q;
  logic       valid_q;
  logic       err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= SEL_NONE;
      sel_p <= SEL_NONE;
      seg_q <= '0;
      seg_p <= '0;
      cnt_q <= '0;
    end else begin
      sel_q <= bus.sel;
      sel_p <= sel_q;
      seg_q <= bus.seg;
      seg_p <= seg_q;
      cnt_q <= cnt_d;
    end
  end

  // Capture fires on the single step from S-2 to S-1.
  always_comb begin
    slot    = sel_to_slot(sel_q);
    idx     = 2'(slot);
    same    = (sel_q == sel_p) && (seg_q == seg_p);
    inc     = (slot != SLOT_NONE) && same;
    capture = inc && (cnt_q == CNT_PRE);
    cnt_d   = '0;
    if (inc) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q
                                 : cnt_q + 8'd1;
    end
  end

  seg_pattern_to_digit u_dec (
    .pattern    (seg_q),
    .digit      (dec_digit),
    .pattern_ok (dec_ok)
  );

  assign frame_done = &cap_q;

  // A capture landing on completion goes into the fresh frame.
  always_comb begin
    cap_d  = frame_done ? 3'b000 : cap_q;
    slot_d = slot_q;
    if (capture) begin
      cap_d[idx]        = 1'b1;
      slot_d[idx].digit = dec_ok ? dec_digit : 4'd0;
      slot_d[idx].err   = !dec_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      cap_q  <= '0;
    end else begin
      slot_q <= slot_d;
      cap_q  <= cap_d;
    end
  end

  always_comb begin
    value = 10'd100 * {6'd0, slot_q[2].digit}
          + 10'd10  * {6'd0, slot_q[1].digit}
          + {6'd0, slot_q[0].digit};
    bad   = slot_q[0].err
          | slot_q[1].err
          | slot_q[2].err
          | (value > 10'd255);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= frame_done;
      err_q   <= frame_done && bad;
      if (frame_done && !bad) begin
        score_q <= value[7:0];
      end
    end
  end

  assign bus.score       = score_q;
  assign bus.score_valid = valid_q;
  assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Randomised scoreboard bench for seven_seg_scan_decoder.
// Stimulus pushes expected frames; a monitor checks every pulse.
module tb_seven_seg_scan_decoder;

  localparam int S = 4;

  typedef struct {
    logic       err;
    logic [7:0] score;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q[$];

  logic [6:0] pat_tbl [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000
  };
  logic [2:0] code_tbl [3] = '{3'b011, 3'b101, 3'b110};
  logic [2:0] none_tbl [5] = '{3'b111, 3'b000, 3'b001, 3'b010, 3'b100};

  int         m_digit [3];
  bit         m_err [3];
  bit         m_cap [3];
  logic [7:0] m_score;
  logic [9:0] last;

  seven_seg_scan_decoder_if bus ();

  seven_seg_scan_decoder #(
    .STABLE_CYCLES (S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 10; i++)
      if (pat_tbl[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_digit[i] = 0;
      m_err[i]   = 0;
      m_cap[i]   = 0;
    end
    m_score = 8'd0;
  endtask

  task automatic model_capture(input int slot, input logic [6:0] p,
                               input int start);
    int   d;
    int   val;
    exp_t e;
    d             = lookup(p);
    m_digit[slot] = (d < 0) ? 0 : d;
    m_err[slot]   = (d < 0);
    m_cap[slot]   = 1;
    if (m_cap[0] && m_cap[1] && m_cap[2]) begin
      val     = m_digit[2] * 100 + m_digit[1] * 10 + m_digit[0];
      e.err   = m_err[0] || m_err[1] || m_err[2] || (val > 255);
      e.score = e.err ? m_score : 8'(val);
      e.cyc   = start + S + 2;
      q.push_back(e);
      if (!e.err) m_score = 8'(val);
      for (int i = 0; i < 3; i++) m_cap[i] = 0;
    end
  endtask

  // slot 0..2 selects a digit, 3 drives a "no digit" code.
  task automatic drive(input int slot, input logic [6:0] p, input int n);
    logic [2:0] code;
    int         start;
    if (slot < 3) begin
      code = code_tbl[slot];
      if ({code, p} == last) begin
        bus.sel = 3'b111;
        last    = {3'b111, p};
        @(negedge clk);
      end
    end else begin
      code = none_tbl[$urandom_range(0, 4)];
    end
    start   = cyc;
    bus.sel = code;
    bus.seg = p;
    last    = {code, p};
    if (slot < 3 && n >= S) model_capture(slot, p, start);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int h, input int t, input int o, input int n);
    drive(0, pat_tbl[o], n);
    drive(1, pat_tbl[t], n);
    drive(2, pat_tbl[h], n);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.score_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid: got pulse score=%0d err=%0b, expected none",
                   bus.score, bus.frame_err);
        end else begin
          e = q.pop_front();
          chk("score", int'(bus.score), int'(e.score));
          chk("frame_err", int'(bus.frame_err), int'(e.err));
          chk("latency_cycle", cyc, e.cyc);
        end
      end else begin
        chk("err_idle", int'(bus.frame_err), 0);
      end
    end
  end

  initial begin
    int         slot;
    logic [6:0] p;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    bus.sel = 3'b111;
    bus.seg = 7'd0;
    last    = 10'h3ff;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_valid", int'(bus.score_valid), 0);
    chk("rst_err", int'(bus.frame_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    drive(0, 7'b1111000, 10);
    drive(1, 7'b0110000, 10);
    drive(2, 7'b1111001, 10);

    frame(2, 5, 5, 6);
    frame(2, 5, 6, 6);

    frame(1, 2, 3, S - 1);
    for (int i = 0; i < 8; i++)
      drive(0, pat_tbl[(i % 2) * 4], 2);

    drive(0, pat_tbl[4], 5);
    drive(1, 7'b1111111, 5);
    drive(2, pat_tbl[1], 5);
    frame(0, 0, 9, 5);

    drive(0, pat_tbl[3], 6);
    drive(1, pat_tbl[4], 6);
    drive(3, 7'd0, 2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_score", int'(bus.score), 0);
    chk("async_rst_valid", int'(bus.score_valid), 0);
    model_reset();
    last = 10'h3ff;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(2, pat_tbl[1], 6);
    drive(3, 7'd0, 6);
    drive(0, pat_tbl[3], 6);
    drive(1, pat_tbl[4], 6);

    frame(1, 9, 8, 200);
    frame(0, 4, 2, 200);

    for (int i = 0; i < 150; i++) begin
      slot = $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 8) p = pat_tbl[$urandom_range(0, 9)];
      else p = 7'($urandom);
      if (slot == 2 && $urandom_range(0, 1) == 1) p = pat_tbl[$urandom_range(0, 2)];
      drive(slot, p, $urandom_range(1, 8));
    end

    drive(3, 7'd0, S + 6);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_decoder.md
SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples of (sel, seg) required before a digit is captured; legal range 2..255.
REQ-002 SHALL have port clk, input, 1, the single clock, all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port sel, input, 3, active-low digit select: 3'b011 = ones, 3'b101 = tens, 3'b110 = hundreds; any other code is "no digit".
REQ-005 SHALL have port seg, input, 7, active-low segment pattern, same encoding as the team's display driver.
REQ-006 SHALL have port score, output, 8, the last successfully reconstructed binary score.
REQ-007 SHALL have port score_valid, output, 1, a one-cycle pulse when a frame completes.
REQ-008 SHALL have port frame_err, output, 1, qualified by score_valid: the frame contained an invalid pattern or a value above 255.

Function
REQ-009 SHALL register sel and seg once per cycle, then compare each registered sample with the previous one.
REQ-010 SHALL keep a stability counter: a valid sel code with an unchanged sample increments it, saturating at STABLE_CYCLES; any change or invalid sel code clears it to 0.
REQ-011 SHALL capture the slot addressed by sel exactly once per dwell, in the cycle the counter reaches STABLE_CYCLES-1.
REQ-012 SHALL NOT capture again while the counter stays saturated in the same dwell.
REQ-013 SHALL decode patterns 0..9 as: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000.
REQ-014 SHALL treat any other pattern as invalid: the slot stores 0 and the slot error bit is set.
REQ-015 SHALL set a per-slot captured bit on capture; recapturing an already captured slot overwrites its digit and error bit, so the newest value wins.
REQ-016 SHALL complete a frame in the cycle after the capture that leaves all three captured bits set.
REQ-017 On frame completion SHALL pulse score_valid for one cycle and clear all captured bits in that same cycle.
REQ-018 SHALL compute value = d2*100 + d1*10 + d0 at 10-bit width.
REQ-019 SHALL set frame_err = 1 if any slot error bit is set or value > 255, and in that case leave score unchanged.
REQ-020 SHALL update score to value[7:0] when frame_err = 0.
REQ-021 SHALL apply a capture that coincides with a frame completion to the newly cleared slot set, so it is not lost.
REQ-022 Latency: the last capture-eligible sample at the inputs SHALL appear as score_valid after STABLE_CYCLES+2 cycles.
REQ-023 SHALL drive frame_err = 0 whenever score_valid = 0.

Reset
REQ-024 On rst_n low, immediately and regardless of clk, SHALL set score = 0, score_valid = 0 and frame_err = 0.
REQ-025 On rst_n low SHALL also clear the counter, input sample registers, slot digits, captured bits and error bits.
REQ-026 Reset mid-frame SHALL discard the partial frame; after rst_n rises, the first capture requires a full STABLE_CYCLES dwell.

Structure
REQ-027 A shared package SHALL hold the three sel codes, the ten-entry segment pattern table, the "no digit" definition and the STABLE_CYCLES default; the team's display driver SHALL use the same package.
REQ-028 SHALL instantiate one combinational sub-module, seg_pattern_to_digit: 7-bit pattern in, 4-bit digit and pattern_ok out.
REQ-029 Everything else SHALL live in the top module: sampling, counter, slots, frame logic.

Verification
REQ-030 Scan ones=1111000, tens=0110000, hundreds=1111001, 10 cycles each -> score_valid pulse, score=137, frame_err=0.
REQ-031 Scan digits 2,5,5 then 2,5,6 -> first frame score=255 with frame_err=0; second frame frame_err=1 with score held at 255.
REQ-032 Each dwell of STABLE_CYCLES-1 = 3 cycles, or seg toggling every 2 cycles -> no capture and no score_valid.
REQ-033 Tens pattern 1111111 within a full frame -> frame_err=1 with score unchanged; a following clean frame of 0,0,9 -> score=9, frame_err=0.
REQ-034 Assert rst_n low after two slots are captured, then release and scan only the third digit -> no score_valid until all three are rescanned.
REQ-035 Continuous scan of one digit held for 200 cycles -> exactly one capture per dwell and exactly one score_valid per complete three-digit cycle.
